// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the two requester ports and the data-memory port that the
// dmem_arbiter sits between.
//   master : arbiter view (takes requests and MEM_RDATA; drives grants,
//            read returns and the memory address/data/strobes)
//   slave  : requester + memory view (the mirror image of master)
// Port 0 is the core load/store path, port 1 the debug/loader DMA.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              REQ0_READ;
  logic              REQ0_WRITE;
  logic [ADDR_W-1:0] REQ0_ADDR;
  logic [DATA_W-1:0] REQ0_WDATA;
  logic              GNT0;
  logic              REQ0_VALID;
  logic [DATA_W-1:0] REQ0_RDATA;

  logic              REQ1_READ;
  logic              REQ1_WRITE;
  logic [ADDR_W-1:0] REQ1_ADDR;
  logic [DATA_W-1:0] REQ1_WDATA;
  logic              GNT1;
  logic              REQ1_VALID;
  logic [DATA_W-1:0] REQ1_RDATA;

  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [DATA_W-1:0] MEM_RDATA;

  modport master (
    input  REQ0_READ, REQ0_WRITE, REQ0_ADDR, REQ0_WDATA,
    input  REQ1_READ, REQ1_WRITE, REQ1_ADDR, REQ1_WDATA,
    input  MEM_RDATA,
    output GNT0, REQ0_VALID, REQ0_RDATA,
    output GNT1, REQ1_VALID, REQ1_RDATA,
    output MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE
  );

  modport slave (
    output REQ0_READ, REQ0_WRITE, REQ0_ADDR, REQ0_WDATA,
    output REQ1_READ, REQ1_WRITE, REQ1_ADDR, REQ1_WDATA,
    output MEM_RDATA,
    input  GNT0, REQ0_VALID, REQ0_RDATA,
    input  GNT1, REQ1_VALID, REQ1_RDATA,
    input  MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one data-memory port between the core (port 0) and the debug/loader
// DMA (port 1). Round-robin arbitration in IDLE with a combinational grant;
// writes complete in the grant cycle, reads block the memory port until the
// fixed read latency has elapsed and then return the data as a one-cycle
// VALID pulse with registered RDATA on the owning port.
// Ports:
//   CLK   : clock, all state on the rising edge
//   RESET : synchronous, active-high reset
//   bus   : dmem_arbiter_if.master (both requester ports + memory port)
// Parameters:
//   ADDR_W, DATA_W : address / data widths
//   RD_LAT         : cycles from the MEM_READ cycle to MEM_RDATA valid (1..7)
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic             CLK,
  input logic             RESET,
  dmem_arbiter_if.master  bus
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state;
  logic              prio;
  logic              owner;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              valid0;
  logic              valid1;

  logic              req0;
  logic              req1;
  logic              win0;
  logic              win1;
  logic              sel_wr;
  logic              sel_rd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    req0 = bus.REQ0_READ | bus.REQ0_WRITE;
    req1 = bus.REQ1_READ | bus.REQ1_WRITE;
    win0 = 1'b0;
    win1 = 1'b0;
    // Grants are only possible from IDLE and never while reset is asserted.
    if (!RESET && state == IDLE) begin
      if (req0 && (!req1 || !prio))
        win0 = 1'b1;
      else if (req1)
        win1 = 1'b1;
    end
    sel_wr    = win0 ? bus.REQ0_WRITE : bus.REQ1_WRITE;
    sel_rd    = win0 ? bus.REQ0_READ  : bus.REQ1_READ;
    sel_addr  = win0 ? bus.REQ0_ADDR  : bus.REQ1_ADDR;
    sel_wdata = win0 ? bus.REQ0_WDATA : bus.REQ1_WDATA;
    mem_addr  = '0;
    mem_wdata = '0;
    if (win0 || win1) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
    end else if (!RESET && state == RD_WAIT) begin
      mem_addr  = rd_addr;
    end
  end

  assign bus.GNT0       = win0;
  assign bus.GNT1       = win1;
  // READ together with WRITE is a plain write: no read sequence is started.
  assign bus.MEM_WRITE  = (win0 | win1) & sel_wr;
  assign bus.MEM_READ   = (win0 | win1) & sel_rd & ~sel_wr;
  assign bus.MEM_ADDR   = mem_addr;
  assign bus.MEM_WDATA  = mem_wdata;
  assign bus.REQ0_VALID = valid0;
  assign bus.REQ1_VALID = valid1;
  assign bus.REQ0_RDATA = rdata0;
  assign bus.REQ1_RDATA = rdata1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      prio   <= 1'b0;
      owner  <= 1'b0;
      cnt    <= 3'd0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (win0 || win1) begin
            // Priority passes to the other port after every grant.
            prio <= win0;
            if (sel_rd && !sel_wr) begin
              state   <= RD_WAIT;
              owner   <= win1;
              cnt     <= 3'd1;
              rd_addr <= sel_addr;
            end
          end
        end
        RD_WAIT: begin
          cnt <= cnt + 3'd1;
          // Memory data is valid in the cycle the count reaches the latency.
          if (cnt == LAT) begin
            state <= IDLE;
            if (owner) begin
              rdata1 <= bus.MEM_RDATA;
              valid1 <= 1'b1;
            end else begin
              rdata0 <= bus.MEM_RDATA;
              valid0 <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
